// File: rtl/s_axi_intc.sv
// s_axi_intc -- AXI4-Lite interrupt controller for up to 32 external lines.
//
// Each line can be level- or rising-edge-sensitive. Status is latched in ISR,
// masked by IER and gated by GIE into a single registered irq.
//
// Register map (byte offset, decode on addr[4:2]):
//   0x00 GIE   bit0 RW global interrupt enable
//   0x04 IER   RW per-line enable
//   0x08 ISR   read status / write-1-to-clear
//   0x0C IPR   ISR & IER, read-only (writes ignored, OKAY)
//   0x10 MODE  RW, 1 = rising edge, 0 = level
//   0x14 ISET  write-1-to-set ISR, reads 0
//   0x18-0x1C  unmapped: SLVERR, reads 0, writes ignored
//
// Ports:
//   s_axi_aclk, s_axi_aresetn      clock, async active-low reset
//   s_axi_aw*/w*/b*                write address / data / response channels
//   s_axi_ar*/r*                   read address / data channels
//   ext_interrupt[NUM_OF_INTR]     asynchronous interrupt sources
//   irq                            registered interrupt request, active high
module s_axi_intc #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int NUM_OF_INTR = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [NUM_OF_INTR-1:0]    ext_interrupt,
    output logic                      irq
);

    localparam logic [2:0] SEL_GIE  = 3'd0;
    localparam logic [2:0] SEL_IER  = 3'd1;
    localparam logic [2:0] SEL_ISR  = 3'd2;
    localparam logic [2:0] SEL_IPR  = 3'd3;
    localparam logic [2:0] SEL_MODE = 3'd4;
    localparam logic [2:0] SEL_ISET = 3'd5;

    // write channel holding registers
    logic                     r_aw_held;
    logic [2:0]               r_awsel;
    logic                     r_w_held;
    logic [NUM_OF_INTR-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0]  r_wstrb;
    logic                     r_awready;
    logic                     r_wready;
    logic                     r_bvalid;
    logic [1:0]               r_bresp;

    // read channel
    logic                     r_arready;
    logic                     r_rvalid;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic [1:0]               r_rresp;

    // register file
    logic                     r_gie;
    logic [NUM_OF_INTR-1:0]   r_ier;
    logic [NUM_OF_INTR-1:0]   r_isr;
    logic [NUM_OF_INTR-1:0]   r_mode;
    logic                     r_irq;

    // interrupt input path
    logic [NUM_OF_INTR-1:0]   r_sync [SYNC_STAGES];
    logic [NUM_OF_INTR-1:0]   r_prev;
    logic [NUM_OF_INTR-1:0]   r_lvl;
    logic [NUM_OF_INTR-1:0]   r_edge;

    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_commit;
    logic                     w_aw_held_nxt;
    logic                     w_w_held_nxt;
    logic                     w_bvalid_nxt;
    logic                     w_ar_hs;
    logic                     w_rvalid_nxt;
    logic [NUM_OF_INTR-1:0]   w_wkeep;
    logic [NUM_OF_INTR-1:0]   w_wbits;
    logic [NUM_OF_INTR-1:0]   w_set;
    logic [NUM_OF_INTR-1:0]   w_clr;
    logic [NUM_OF_INTR-1:0]   w_src;
    logic [NUM_OF_INTR-1:0]   w_sync;
    logic [DATA_WIDTH-1:0]    w_rd_data;
    logic [1:0]               w_rd_resp;
    logic                     w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                        s_axi_araddr[1:0], s_axi_wdata, r_wstrb};

    assign w_aw_hs  = s_axi_awvalid & r_awready;
    assign w_w_hs   = s_axi_wvalid & r_wready;
    // a pending B response blocks the next commit even if AW/W are held
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

    assign w_aw_held_nxt = (r_aw_held & ~w_commit) | w_aw_hs;
    assign w_w_held_nxt  = (r_w_held & ~w_commit) | w_w_hs;
    assign w_bvalid_nxt  = w_commit | (r_bvalid & ~s_axi_bready);

    assign w_ar_hs      = s_axi_arvalid & r_arready;
    assign w_rvalid_nxt = w_ar_hs | (r_rvalid & ~s_axi_rready);

    always_comb begin
        w_wkeep = '0;
        for (int i = 0; i < NUM_OF_INTR; i++) begin
            w_wkeep[i] = r_wstrb[i/8];
        end
    end

    assign w_wbits = r_wdata & w_wkeep;
    assign w_set   = (w_commit && r_awsel == SEL_ISET) ? w_wbits : '0;
    assign w_clr   = (w_commit && r_awsel == SEL_ISR)  ? w_wbits : '0;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_src  = (r_mode & r_edge) | (~r_mode & r_lvl);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = 2'b00;
        case (s_axi_araddr[4:2])
            SEL_GIE:  w_rd_data[0]               = r_gie;
            SEL_IER:  w_rd_data[NUM_OF_INTR-1:0] = r_ier;
            SEL_ISR:  w_rd_data[NUM_OF_INTR-1:0] = r_isr;
            SEL_IPR:  w_rd_data[NUM_OF_INTR-1:0] = r_isr & r_ier;
            SEL_MODE: w_rd_data[NUM_OF_INTR-1:0] = r_mode;
            SEL_ISET: w_rd_data                  = '0;
            default:  w_rd_resp                  = 2'b10;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_aw_held <= 1'b0;
            r_awsel   <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            r_awready <= ~w_aw_held_nxt;
            r_wready  <= ~w_w_held_nxt;
            r_bvalid  <= w_bvalid_nxt;
            if (w_aw_hs) begin
                r_awsel <= s_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata[NUM_OF_INTR-1:0];
                r_wstrb <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_bresp <= (r_awsel > SEL_ISET) ? 2'b10 : 2'b00;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_gie  <= 1'b0;
            r_ier  <= '0;
            r_mode <= '0;
            r_isr  <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_commit && r_awsel == SEL_GIE && r_wstrb[0]) begin
                r_gie <= r_wdata[0];
            end
            if (w_commit && r_awsel == SEL_IER) begin
                r_ier <= (r_ier & ~w_wkeep) | w_wbits;
            end
            if (w_commit && r_awsel == SEL_MODE) begin
                r_mode <= (r_mode & ~w_wkeep) | w_wbits;
            end
            // set terms are OR'd after the clear mask so a same-cycle set wins
            r_isr <= w_src | w_set | (r_isr & ~w_clr);
            r_irq <= r_gie & (|(r_isr & r_ier));
        end
    end

    // r_lvl/r_edge add one register after the synchroniser so that the
    // detector output is clean before it meets MODE and ISR. r_prev always
    // tracks the synchronised level, so a MODE flip never fakes an edge.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_lvl  <= '0;
            r_edge <= '0;
        end else begin
            r_sync[0] <= ext_interrupt;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
            r_lvl  <= w_sync;
            r_edge <= w_sync & ~r_prev;
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign irq           = r_irq;

endmodule

// File: tb/tb_s_axi_intc.sv
// Directed testbench for s_axi_intc (default parameters: 8 lines, 2 sync stages).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_s_axi_intc;

    logic        clk = 1'b0;
    logic        s_axi_aresetn;
    logic [4:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [4:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [7:0]  ext_interrupt;
    logic        irq;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    s_axi_intc dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (s_axi_aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .ext_interrupt (ext_interrupt),
        .irq           (irq)
    );

    // Called on a falling edge; returns on a falling edge after B completes.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        logic aw_done, w_done, awr, wr;
        int n;
        aw_done = 1'b0; w_done = 1'b0; n = 0; resp = 2'b11;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            awr = s_axi_awready; wr = s_axi_wready;
            @(posedge clk);
            if (awr && s_axi_awvalid) aw_done = 1'b1;
            if (wr && s_axi_wvalid) w_done = 1'b1;
            @(negedge clk);
            if (aw_done) s_axi_awvalid = 1'b0;
            if (w_done) s_axi_wvalid = 1'b0;
            n++;
        end
        while (!s_axi_bvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!s_axi_bvalid) begin
            failures++;
            $display("FAIL write_timeout addr=%h: bvalid=0, required 1", a);
        end else begin
            resp = s_axi_bresp;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] data,
                            output logic [1:0] resp);
        logic done, arr;
        int n;
        done = 1'b0; n = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        while (!done && n < 20) begin
            arr = s_axi_arready;
            @(posedge clk);
            if (arr) done = 1'b1;
            @(negedge clk);
            if (done) s_axi_arvalid = 1'b0;
            n++;
        end
        while (!s_axi_rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!s_axi_rvalid) begin
            failures++;
            $display("FAIL read_timeout addr=%h: rvalid=0, required 1", a);
        end else begin
            data = s_axi_rdata;
            resp = s_axi_rresp;
        end
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic [4:0]  a;
        s_axi_aresetn = 1'b0;
        wait_cycles(3);
        tests++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             s_axi_bresp, s_axi_rresp, s_axi_rdata, irq} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero, required all 0");
        end
        s_axi_aresetn = 1'b1;
        wait_cycles(2);
        tests++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready: aw/w/ar ready=%b, required 111",
                     {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        for (int i = 0; i < 6; i++) begin
            a = 5'(i * 4);
            axi_read(a, d, r);
            tests++;
            if (d !== 32'h0 || r !== 2'b00) begin
                failures++;
                $display("FAIL reset_read addr=%h: data=%h resp=%b, required 0 / 00", a, d, r);
            end
        end
        axi_read(5'h18, d, r);
        tests++;
        if (d !== 32'h0 || r !== 2'b10) begin
            failures++;
            $display("FAIL unmapped_read: data=%h resp=%b, required 0 / 10", d, r);
        end
    endtask

    task automatic test_edge_irq();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h04, 32'hFF, 4'hF, r);
        axi_write(5'h00, 32'h1, 4'hF, r);
        axi_write(5'h10, 32'h01, 4'hF, r);
        ext_interrupt[0] = 1'b1;       // sampled at edge k
        @(negedge clk);
        ext_interrupt[0] = 1'b0;
        wait_cycles(3);                // after k+3
        tests++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL edge_irq_early: irq=%b at k+3, required 0", irq);
        end
        @(negedge clk);                // after k+4
        tests++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL edge_irq_latency: irq=%b at k+4, required 1", irq);
        end
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h01) begin
            failures++;
            $display("FAIL edge_isr: ISR=%h, required 00000001", d);
        end
        axi_read(5'h0C, d, r);
        tests++;
        if (d !== 32'h01) begin
            failures++;
            $display("FAIL edge_ipr: IPR=%h, required 00000001", d);
        end
        axi_write(5'h08, 32'h01, 4'hF, r);
        tests++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_irq: irq=%b after clear, required 0", irq);
        end
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL w1c_isr: ISR=%h, required 00000000", d);
        end
    endtask

    task automatic test_level();
        logic [31:0] d;
        logic [1:0]  r;
        ext_interrupt[3] = 1'b1;
        wait_cycles(6);
        axi_write(5'h08, 32'h08, 4'hF, r);
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h08 || irq !== 1'b1) begin
            failures++;
            $display("FAIL level_hold: ISR=%h irq=%b, required 00000008 / 1", d, irq);
        end
        ext_interrupt[3] = 1'b0;
        wait_cycles(6);
        axi_write(5'h08, 32'h08, 4'hF, r);
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL level_clear: ISR=%h irq=%b, required 00000000 / 0", d, irq);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  bresp_seen;
        logic        done;
        int          n, bcount;
        axi_write(5'h04, 32'h0, 4'hF, r);
        s_axi_awaddr = 5'h04; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            done = s_axi_awready;
            @(negedge clk);
            n++;
        end
        s_axi_awvalid = 1'b0;
        tests++;
        if (!done || s_axi_awready !== 1'b0) begin
            failures++;
            $display("FAIL split_aw_held: accepted=%b awready=%b, required 1 / 0", done, s_axi_awready);
        end
        bcount = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) bcount++;
        end
        s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'b0001; s_axi_wvalid = 1'b1;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            done = s_axi_wready;
            @(negedge clk);
            n++;
        end
        s_axi_wvalid = 1'b0;
        bresp_seen = 2'b11;
        if (s_axi_bvalid) begin bcount++; bresp_seen = s_axi_bresp; end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_axi_bvalid) begin bcount++; bresp_seen = s_axi_bresp; end
        end
        s_axi_bready = 1'b0;
        tests++;
        if (bcount != 1 || bresp_seen !== 2'b00) begin
            failures++;
            $display("FAIL split_bvalid: bvalid cycles=%0d bresp=%b, required 1 / 00", bcount, bresp_seen);
        end
        axi_read(5'h04, d, r);
        tests++;
        if (d !== 32'hFF) begin
            failures++;
            $display("FAIL split_ier: IER=%h, required 000000FF", d);
        end
        axi_write(5'h04, 32'h0, 4'b0010, r);
        axi_read(5'h04, d, r);
        tests++;
        if (d !== 32'hFF) begin
            failures++;
            $display("FAIL wstrb_lane_off: IER=%h, required 000000FF", d);
        end
        axi_write(5'h1C, 32'hFF, 4'hF, r);
        tests++;
        if (r !== 2'b10) begin
            failures++;
            $display("FAIL unmapped_write: bresp=%b, required 10", r);
        end
        axi_write(5'h0C, 32'hFF, 4'hF, r);
        axi_read(5'h0C, d, r);
        tests++;
        if (d !== 32'h0 || r !== 2'b00) begin
            failures++;
            $display("FAIL ipr_readonly: IPR=%h resp=%b, required 0 / 00", d, r);
        end
    endtask

    task automatic test_ier_late();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h04, 32'h0, 4'hF, r);
        axi_write(5'h14, 32'h02, 4'hF, r);
        axi_read(5'h0C, d, r);
        tests++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL ier_off: IPR=%h irq=%b, required 0 / 0", d, irq);
        end
        axi_read(5'h14, d, r);
        tests++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL iset_reads_zero: ISET=%h, required 0", d);
        end
        axi_write(5'h04, 32'h02, 4'hF, r);
        axi_read(5'h0C, d, r);
        tests++;
        if (d !== 32'h02 || irq !== 1'b1) begin
            failures++;
            $display("FAIL ier_late: IPR=%h irq=%b, required 00000002 / 1", d, irq);
        end
        axi_write(5'h08, 32'h02, 4'hF, r);
        axi_write(5'h04, 32'hFF, 4'hF, r);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h10, 32'h05, 4'hF, r);
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL set_wins_pre: ISR=%h, required 0", d);
        end
        ext_interrupt[2] = 1'b1;       // sampled at edge k
        @(negedge clk);
        ext_interrupt[2] = 1'b0;
        @(negedge clk);
        // handshake at k+2, commit at k+3 together with the detected edge
        axi_write(5'h08, 32'h04, 4'hF, r);
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h04) begin
            failures++;
            $display("FAIL set_wins: ISR=%h, required 00000004", d);
        end
        axi_write(5'h08, 32'h04, 4'hF, r);
        axi_read(5'h08, d, r);
        tests++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL edge_w1c: ISR=%h, required 0", d);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r;
        logic       done;
        int         n, bad_b, bad_r;
        axi_write(5'h14, 32'h02, 4'hF, r);
        s_axi_awaddr = 5'h04; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5A; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b0;
        @(negedge clk);                // both accepted this edge
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 10) begin @(negedge clk); n++; end
        bad_b = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) bad_b++;
            @(negedge clk);
        end
        tests++;
        if (bad_b != 0) begin
            failures++;
            $display("FAIL bready_stall: %0d unstable cycles, required 0", bad_b);
        end
        s_axi_araddr = 5'h04; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        done = 1'b0; n = 0;
        while (!done && n < 20) begin
            done = s_axi_arready;
            @(negedge clk);
            n++;
        end
        s_axi_araddr = 5'h10;          // second request must wait
        bad_r = 0;
        for (int i = 0; i < 5; i++) begin
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h5A ||
                s_axi_rresp !== 2'b00 || s_axi_arready !== 1'b0) bad_r++;
            @(negedge clk);
        end
        tests++;
        if (!done || bad_r != 0) begin
            failures++;
            $display("FAIL rready_stall: accepted=%b unstable cycles=%0d, required 1 / 0", done, bad_r);
        end
        tests++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq: irq=%b, required 1", irq);
        end
        #2;
        s_axi_aresetn = 1'b0;
        #1;
        tests++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
             s_axi_bresp, s_axi_rresp, s_axi_rdata, irq} !== '0) begin
            failures++;
            $display("FAIL reset_mid: outputs rdata=%h bvalid=%b rvalid=%b irq=%b, required all 0",
                     s_axi_rdata, s_axi_bvalid, s_axi_rvalid, irq);
        end
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        s_axi_aresetn = 1'b1;
        wait_cycles(2);
    endtask

    initial begin
        s_axi_aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        ext_interrupt = '0;
        @(negedge clk);
        test_reset();
        test_edge_irq();
        test_level();
        test_split_write();
        test_ier_late();
        test_set_wins();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
